// File: rtl/sim_run_ctrl_pkg.sv
// Shared types and defaults for the simulation run controller.
// Latency: n/a (types only). Backpressure: n/a.
package sim_run_ctrl_pkg;

    localparam int XLEN = 32;

    localparam int              DEF_N_CH           = 1;
    localparam int              DEF_RESET_CYCLES   = 4;
    localparam int              DEF_TIMEOUT_CYCLES = 1_000_000;
    localparam int              DEF_STALL_CYCLES   = 8;
    localparam logic [XLEN-1:0] DEF_PASS_SIG       = 32'h0000_0001;

    typedef enum logic [1:0] {
        HOLD,
        RUN,
        DONE,
        TIMEOUT
    } run_state_e;

    function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/sim_run_halt_det.sv
// Per-core halt detector: flags a core whose PC repeats STALL_CYCLES times in a row.
// Latency: halted registers on the edge of the last identical sample; halt_nxt is that edge's value.
// Backpressure: none; samples every cycle while run_en. Misalign tracking under SIM_RUN_CTRL_PCALIGN_EN.
module sim_run_halt_det
    import sim_run_ctrl_pkg::*;
#(
    parameter int STALL_CYCLES = DEF_STALL_CYCLES
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            run_en,
    input  logic            first_smp,
    input  logic [XLEN-1:0] pc,
    output logic            halted,
    output logic            halt_nxt
`ifdef SIM_RUN_CTRL_PCALIGN_EN
    ,
    output logic            misalign_nxt
`endif
);

    localparam int SC_W = $clog2(STALL_CYCLES);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STALL_CYCLES - 1);

    logic [XLEN-1:0] last_pc;
    logic [SC_W-1:0] stall_cnt;
    logic [SC_W-1:0] cnt_inc;
    logic            pc_same;

    // The first run sample has nothing to compare against.
    assign pc_same  = (pc == last_pc) && !first_smp;
    assign cnt_inc  = (stall_cnt == SC_MAX) ? SC_MAX : stall_cnt + SC_W'(1);
    assign halt_nxt = halted | (run_en && pc_same && (cnt_inc == SC_MAX));

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            last_pc   <= '0;
            stall_cnt <= '0;
            halted    <= 1'b0;
        end else if (run_en) begin
            last_pc   <= pc;
            stall_cnt <= pc_same ? cnt_inc : '0;
            halted    <= halt_nxt;
        end
    end

`ifdef SIM_RUN_CTRL_PCALIGN_EN
    logic misalign;

    assign misalign_nxt = misalign | (run_en && pc_misaligned(pc));

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            misalign <= 1'b0;
        end else begin
            misalign <= misalign_nxt;
        end
    end
`endif

endmodule

// File: rtl/sim_run_ctrl.sv
// Run controller: sequences core reset, watches N_CH cores for PC self-loop, reports done/pass/timeout.
// Latency: core reset releases RESET_CYCLES edges after i_reset; verdict registers with the last halt flag.
// Backpressure: none; terminal states freeze all outputs until i_reset. Option: SIM_RUN_CTRL_PCALIGN_EN.
module sim_run_ctrl
    import sim_run_ctrl_pkg::*;
#(
    parameter int              N_CH           = DEF_N_CH,
    parameter int              RESET_CYCLES   = DEF_RESET_CYCLES,
    parameter int              TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int              STALL_CYCLES   = DEF_STALL_CYCLES,
    parameter logic [XLEN-1:0] PASS_SIG       = DEF_PASS_SIG,
    localparam int             CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [XLEN*N_CH-1:0] i_pc_debug,
    input  logic [XLEN*N_CH-1:0] i_io_ledr,
    output logic                 o_core_reset,
    output logic [N_CH-1:0]      o_halted,
    output logic [CNT_W-1:0]     o_cycle_cnt,
    output logic                 o_done,
    output logic                 o_pass,
    output logic                 o_timeout
);

    localparam int HOLD_W = $clog2(RESET_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    run_state_e        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [N_CH-1:0]   halt_nxt;
    logic              run_en;
    logic              first_smp;
    logic              ledr_ok;
    logic              verdict_pass;

    assign run_en    = (state == RUN);
    assign first_smp = (o_cycle_cnt == '0);

`ifdef SIM_RUN_CTRL_PCALIGN_EN
    logic [N_CH-1:0] misalign_nxt;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        sim_run_halt_det #(
            .STALL_CYCLES(STALL_CYCLES)
        ) u_det (
            .i_clk       (i_clk),
            .i_reset     (i_reset),
            .run_en      (run_en),
            .first_smp   (first_smp),
            .pc          (i_pc_debug[i*XLEN +: XLEN]),
            .halted      (o_halted[i]),
            .halt_nxt    (halt_nxt[i])
`ifdef SIM_RUN_CTRL_PCALIGN_EN
            ,
            .misalign_nxt(misalign_nxt[i])
`endif
        );
    end

    always_comb begin
        ledr_ok = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (i_io_ledr[i*XLEN +: XLEN] != PASS_SIG) begin
                ledr_ok = 1'b0;
            end
        end
    end

`ifdef SIM_RUN_CTRL_PCALIGN_EN
    assign verdict_pass = ledr_ok && !(|misalign_nxt);
`else
    assign verdict_pass = ledr_ok;
`endif

    // All-halted is judged on the next-state halt flags so the verdict lands
    // on the same edge as the final halt, and beats a coincident timeout.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state        <= HOLD;
            hold_cnt     <= '0;
            o_cycle_cnt  <= '0;
            o_core_reset <= 1'b0;
            o_done       <= 1'b0;
            o_pass       <= 1'b0;
            o_timeout    <= 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state        <= RUN;
                        o_core_reset <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                RUN: begin
                    if (&halt_nxt) begin
                        state  <= DONE;
                        o_done <= 1'b1;
                        o_pass <= verdict_pass;
                    end else if (o_cycle_cnt == CNT_LAST) begin
                        state     <= TIMEOUT;
                        o_done    <= 1'b1;
                        o_timeout <= 1'b1;
                    end else begin
                        o_cycle_cnt <= o_cycle_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Randomised scenario bench for sim_run_ctrl against a trace-level reference model.
module tb_sim_run_ctrl;

    localparam int          NC = 2;
    localparam int          RC = 4;
    localparam int          TC = 100;
    localparam int          SC = 8;
    localparam logic [31:0] PS = 32'h0000_0001;
    localparam int          CW = $clog2(TC + 1);

    logic               i_clk;
    logic               i_reset;
    logic [32*NC-1:0]   i_pc_debug;
    logic [32*NC-1:0]   i_io_ledr;
    logic               o_core_reset;
    logic [NC-1:0]      o_halted;
    logic [CW-1:0]      o_cycle_cnt;
    logic               o_done;
    logic               o_pass;
    logic               o_timeout;

    sim_run_ctrl #(
        .N_CH          (NC),
        .RESET_CYCLES  (RC),
        .TIMEOUT_CYCLES(TC),
        .STALL_CYCLES  (SC),
        .PASS_SIG      (PS)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_pc_debug  (i_pc_debug),
        .i_io_ledr   (i_io_ledr),
        .o_core_reset(o_core_reset),
        .o_halted    (o_halted),
        .o_cycle_cnt (o_cycle_cnt),
        .o_done      (o_done),
        .o_pass      (o_pass),
        .o_timeout   (o_timeout)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] pc_tr [NC][TC];
    logic [31:0] ledr_v [NC];

    int h_exp [NC];
    int term_exp;
    bit done_exp;
    bit pass_exp;

    // Reference: halt index is where a run of SC equal samples first completes;
    // the run ends at the latest halt, or at the budget if that comes first.
    function automatic void model();
        int rl;
        int dmax;
        dmax = 0;
        for (int c = 0; c < NC; c++) begin
            h_exp[c] = TC;
            rl = 0;
            for (int k = 0; k < TC; k++) begin
                rl = (k > 0 && pc_tr[c][k] == pc_tr[c][k-1]) ? rl + 1 : 1;
                if (rl >= SC && h_exp[c] == TC) h_exp[c] = k;
            end
            if (h_exp[c] > dmax) dmax = h_exp[c];
        end
        done_exp = (dmax <= TC - 1);
        term_exp = done_exp ? dmax : TC - 1;
        pass_exp = done_exp;
        for (int c = 0; c < NC; c++)
            if (ledr_v[c] != PS) pass_exp = 1'b0;
`ifdef SIM_RUN_CTRL_PCALIGN_EN
        for (int c = 0; c < NC; c++)
            for (int k = 0; k <= term_exp; k++)
                if (pc_tr[c][k][1:0] != 2'b00) pass_exp = 1'b0;
`endif
    endfunction

    function automatic void fill_ramp(input int c, input int stick_k, input logic [31:0] base,
                                      input logic [31:0] stick_val);
        for (int k = 0; k < TC; k++)
            pc_tr[c][k] = (k < stick_k) ? base + 32'(4 * k) : stick_val;
    endfunction

    task automatic apply_reset();
        i_reset = 1'b0;
        @(posedge i_clk);
        #1;
    endtask

    // Releases reset, checks the hold phase, then plays the trace and compares every edge.
    task automatic run_trace(input string nm, input int abort_k);
        logic [12:0]   obs;
        logic [12:0]   exp;
        logic [NC-1:0] eh;
        int            kk;
        model();
        i_reset = 1'b1;
        for (int e = 1; e <= RC; e++) begin
            @(posedge i_clk);
            #1;
            obs = {o_core_reset, o_halted, o_cycle_cnt, o_done, o_pass, o_timeout};
            exp = {(e == RC), 12'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s hold edge=%0d got=%h exp=%h", nm, e, obs, exp);
            end
        end
        for (int k = 0; k < term_exp + 10; k++) begin
            for (int c = 0; c < NC; c++) begin
                i_pc_debug[c*32 +: 32] = (k < TC) ? pc_tr[c][k] : $urandom;
                i_io_ledr[c*32 +: 32]  = (k <= term_exp) ? ledr_v[c] : $urandom;
            end
            @(posedge i_clk);
            #1;
            kk = (k < term_exp) ? k : term_exp;
            for (int c = 0; c < NC; c++) eh[c] = (h_exp[c] <= kk);
            exp = {1'b1, eh, CW'((k < term_exp) ? k + 1 : term_exp), (k >= term_exp),
                   (k >= term_exp) && pass_exp, (k >= term_exp) && !done_exp};
            obs = {o_core_reset, o_halted, o_cycle_cnt, o_done, o_pass, o_timeout};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s run k=%0d got=%h exp=%h", nm, k, obs, exp);
            end
            if (k == abort_k) return;
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        #1;
        checks++;
        if ({o_core_reset, o_halted, o_cycle_cnt, o_done, o_pass, o_timeout} !== 13'b0) begin
            errors++;
            $display("FAIL reset_async got=%b exp=0", {o_core_reset, o_halted, o_cycle_cnt,
                                                      o_done, o_pass, o_timeout});
        end
        @(posedge i_clk);
        #1;
        checks++;
        if (o_core_reset !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_held core_reset=%b done=%b exp=0/0", o_core_reset, o_done);
        end
    endtask

    task automatic test_single_halt();
        apply_reset();
        for (int c = 0; c < NC; c++) begin
            fill_ramp(c, 16, 32'h0, 32'h40);
            ledr_v[c] = PS;
        end
        run_trace("single_halt", -1);
        checks++;
        if ({o_halted, o_done, o_pass, o_timeout, o_cycle_cnt} !== {2'b11, 3'b110, CW'(23)}) begin
            errors++;
            $display("FAIL single_halt_final halted=%b done=%b pass=%b to=%b cnt=%0d exp 11/1/1/0/23",
                     o_halted, o_done, o_pass, o_timeout, o_cycle_cnt);
        end
    endtask

    task automatic test_two_ch();
        apply_reset();
        fill_ramp(0, 10, 32'h0, 32'h40);
        fill_ramp(1, 30, 32'h1000, 32'h2000);
        ledr_v[0] = PS;
        ledr_v[1] = 32'h0;
        run_trace("two_ch", -1);
        checks++;
        if ({o_halted, o_done, o_pass, o_timeout} !== 5'b11100) begin
            errors++;
            $display("FAIL two_ch_final halted=%b done=%b pass=%b to=%b exp 11/1/0/0",
                     o_halted, o_done, o_pass, o_timeout);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        for (int c = 0; c < NC; c++) begin
            fill_ramp(c, TC, 32'h100 * c, 32'h0);
            ledr_v[c] = PS;
        end
        run_trace("timeout", -1);
        checks++;
        if ({o_done, o_pass, o_timeout, o_cycle_cnt} !== {3'b101, CW'(TC - 1)}) begin
            errors++;
            $display("FAIL timeout_final done=%b pass=%b to=%b cnt=%0d exp 1/0/1/%0d",
                     o_done, o_pass, o_timeout, o_cycle_cnt, TC - 1);
        end
    endtask

    task automatic test_boundary();
        apply_reset();
        fill_ramp(0, 5, 32'h0, 32'h80);
        fill_ramp(1, TC - SC, 32'h400, 32'h9000);
        ledr_v[0] = PS;
        ledr_v[1] = PS;
        run_trace("boundary", -1);
        checks++;
        if ({o_done, o_pass, o_timeout, o_cycle_cnt} !== {3'b110, CW'(TC - 1)}) begin
            errors++;
            $display("FAIL boundary_final done=%b pass=%b to=%b cnt=%0d exp 1/1/0/%0d",
                     o_done, o_pass, o_timeout, o_cycle_cnt, TC - 1);
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        fill_ramp(0, 20, 32'h0, 32'h200);
        fill_ramp(1, 25, 32'h800, 32'h300);
        ledr_v[0] = PS;
        ledr_v[1] = PS;
        run_trace("mid_reset_a", 15);
        #2;
        i_reset = 1'b0;
        #1;
        checks++;
        if ({o_core_reset, o_halted, o_cycle_cnt, o_done, o_pass, o_timeout} !== 13'b0) begin
            errors++;
            $display("FAIL mid_reset_async got=%b exp=0", {o_core_reset, o_halted, o_cycle_cnt,
                                                          o_done, o_pass, o_timeout});
        end
        @(posedge i_clk);
        #1;
        run_trace("mid_reset_b", -1);
    endtask

    task automatic test_misalign();
        apply_reset();
        fill_ramp(0, 10, 32'h0, 32'h40);
        fill_ramp(1, 12, 32'h0, 32'h60);
        pc_tr[1][3] = 32'h42;
        ledr_v[0] = PS;
        ledr_v[1] = PS;
        run_trace("misalign", -1);
        checks++;
`ifdef SIM_RUN_CTRL_PCALIGN_EN
        if (o_pass !== 1'b0) begin
`else
        if (o_pass !== 1'b1) begin
`endif
            errors++;
            $display("FAIL misalign_pass got=%b", o_pass);
        end
    endtask

    task automatic test_random();
        int stick;
        logic [31:0] sv;
        for (int it = 0; it < 6; it++) begin
            apply_reset();
            for (int c = 0; c < NC; c++) begin
                stick = $urandom_range(0, TC + 20);
                sv = {$urandom_range(0, 255), 2'b00};
                for (int k = 0; k < TC; k++) begin
                    pc_tr[c][k] = (k < stick) ? {$urandom_range(0, 3), 2'b00} : sv;
                    if ($urandom_range(0, 40) == 0) pc_tr[c][k][0] = 1'b1;
                end
                ledr_v[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : PS;
            end
            run_trace($sformatf("random%0d", it), -1);
        end
    endtask

    initial begin
        i_reset    = 1'b0;
        i_pc_debug = '0;
        i_io_ledr  = '0;
        test_reset();
        test_single_halt();
        test_two_ch();
        test_timeout();
        test_boundary();
        test_mid_reset();
        test_misalign();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
